// File: rtl/nios_system_sound_i2s_tx.sv
// nios_system_sound_i2s_tx
// I2S master transmitter for the board audio DAC. It latches one mono sample
// from the sound PIO per frame and sends it in both the left and right slots.
// Data goes out MSB first, one BCLK after each LRCLK edge. The rest of each
// slot is zero padding. Every link output comes straight from a flop.
// A stop request lets the current frame finish before the link goes idle.

module nios_system_sound_i2s_tx #(
  parameter int CLK_DIV  = 16,  // clk cycles per BCLK half-period
  parameter int SAMPLE_W = 16,  // sample width
  parameter int SLOT_W   = 32   // BCLK periods per channel slot
) (
  input  logic                clk,
  input  logic                reset_n,
  input  logic                enable,
  input  logic [SAMPLE_W-1:0] sample_in,
  output logic                bclk,
  output logic                lrclk,
  output logic                sdata,
  output logic                frame_strobe,
  output logic                busy
);

  localparam int FRAME_BITS = 2 * SLOT_W;
  localparam int DIV_W      = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
  localparam int BIT_W      = $clog2(FRAME_BITS);

  localparam logic [DIV_W-1:0] DIV_LAST   = DIV_W'(CLK_DIV - 1);
  localparam logic [BIT_W-1:0] FRAME_LAST = BIT_W'(FRAME_BITS - 1);

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_STOP = 2'd2
  } state_e;

  state_e              state_q, state_d;
  logic [DIV_W-1:0]    div_cnt_q, div_cnt_d;
  logic [BIT_W-1:0]    bit_cnt_q, bit_cnt_d;
  logic [SAMPLE_W-1:0] shadow_q, shadow_d;
  logic                bclk_q, bclk_d;
  logic                lrclk_q, lrclk_d;
  logic                sdata_q, sdata_d;
  logic                strobe_q, strobe_d;
  logic                busy_q, busy_d;

  logic                div_wrap_s;
  logic                fall_s;
  logic                boundary_s;

  // Serial bit for a frame position. Slot position 0 is the one-BCLK gap
  // after the LRCLK edge. Positions 1..SAMPLE_W carry the sample MSB first.
  // The remaining positions of the slot are zero.
  function automatic logic slot_bit(input logic [SAMPLE_W-1:0] shadow,
                                    input logic [BIT_W-1:0]    cnt);
    int   pos;
    logic b;
    pos = int'(cnt);
    if (pos >= SLOT_W) begin
      pos = pos - SLOT_W;
    end else begin
      pos = pos;
    end
    b = 1'b0;
    for (int i = 0; i < SAMPLE_W; i++) begin
      if (pos == (SAMPLE_W - i)) begin
        b = shadow[i];
      end else begin
        b = b;
      end
    end
    return b;
  endfunction

  // Decode divider wrap, the BCLK falling event and the last fall of a frame.
  always_comb begin
    div_wrap_s = (div_cnt_q == DIV_LAST);
    fall_s     = div_wrap_s & bclk_q;
    boundary_s = fall_s & (bit_cnt_q == FRAME_LAST);
  end

  // Link sequencer: next state, counters, shadow sample and next outputs.
  always_comb begin
    state_d   = state_q;
    div_cnt_d = div_cnt_q;
    bit_cnt_d = bit_cnt_q;
    shadow_d  = shadow_q;
    bclk_d    = bclk_q;
    lrclk_d   = lrclk_q;
    sdata_d   = sdata_q;
    strobe_d  = 1'b0;

    case (state_q)
      ST_IDLE: begin
        // Outputs stay low while idle. The shadow keeps the last sample.
        div_cnt_d = {DIV_W{1'b0}};
        bit_cnt_d = {BIT_W{1'b0}};
        bclk_d    = 1'b0;
        lrclk_d   = 1'b0;
        sdata_d   = 1'b0;
        if (enable) begin
          state_d  = ST_RUN;
          shadow_d = sample_in;
          strobe_d = 1'b1;
        end else begin
          state_d  = ST_IDLE;
        end
      end

      ST_RUN, ST_STOP: begin
        // Follow the enable level on every cycle. STOP only decides what
        // happens at the end of the frame.
        state_d = enable ? ST_RUN : ST_STOP;

        if (div_wrap_s) begin
          div_cnt_d = {DIV_W{1'b0}};
          bclk_d    = ~bclk_q;
        end else begin
          div_cnt_d = div_cnt_q + DIV_W'(1);
        end

        if (boundary_s && (state_q == ST_STOP)) begin
          // The stopped frame has finished. Go idle without latching a new sample.
          state_d   = ST_IDLE;
          div_cnt_d = {DIV_W{1'b0}};
          bit_cnt_d = {BIT_W{1'b0}};
          bclk_d    = 1'b0;
          lrclk_d   = 1'b0;
          sdata_d   = 1'b0;
        end else if (boundary_s) begin
          // Start the next frame straight away with a fresh sample.
          bit_cnt_d = {BIT_W{1'b0}};
          shadow_d  = sample_in;
          strobe_d  = 1'b1;
          lrclk_d   = 1'b0;
          sdata_d   = 1'b0;
        end else if (fall_s) begin
          bit_cnt_d = bit_cnt_q + BIT_W'(1);
          lrclk_d   = (int'(bit_cnt_d) >= SLOT_W);
          sdata_d   = slot_bit(shadow_q, bit_cnt_d);
        end else begin
          bit_cnt_d = bit_cnt_q;
        end
      end

      default: begin
        state_d   = ST_IDLE;
        div_cnt_d = {DIV_W{1'b0}};
        bit_cnt_d = {BIT_W{1'b0}};
        bclk_d    = 1'b0;
        lrclk_d   = 1'b0;
        sdata_d   = 1'b0;
      end
    endcase

    busy_d = (state_d != ST_IDLE);
  end

  // State, counter, shadow and output registers. Reset forces idle at once.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q   <= ST_IDLE;
      div_cnt_q <= {DIV_W{1'b0}};
      bit_cnt_q <= {BIT_W{1'b0}};
      shadow_q  <= {SAMPLE_W{1'b0}};
      bclk_q    <= 1'b0;
      lrclk_q   <= 1'b0;
      sdata_q   <= 1'b0;
      strobe_q  <= 1'b0;
      busy_q    <= 1'b0;
    end else begin
      state_q   <= state_d;
      div_cnt_q <= div_cnt_d;
      bit_cnt_q <= bit_cnt_d;
      shadow_q  <= shadow_d;
      bclk_q    <= bclk_d;
      lrclk_q   <= lrclk_d;
      sdata_q   <= sdata_d;
      strobe_q  <= strobe_d;
      busy_q    <= busy_d;
    end
  end

  assign bclk         = bclk_q;
  assign lrclk        = lrclk_q;
  assign sdata        = sdata_q;
  assign frame_strobe = strobe_q;
  assign busy         = busy_q;

endmodule
